// File: rtl/gb_cfg_pkg.sv
// gb_cfg_pkg: shared constants and types for the Gaussian-blur config master.
//   - s_axi_config register map and AP_CTRL bit positions
//   - err_code encoding reported on the err_code output
//   - top-level FSM state encoding
package gb_cfg_pkg;

  // s_axi_config register map
  localparam int unsigned AddrApCtrl = 32'h00;
  localparam int unsigned AddrGie    = 32'h04;
  localparam int unsigned AddrIer    = 32'h08;

  // AP_CTRL bit positions
  localparam int unsigned ApStartBit = 0;
  localparam int unsigned ApDoneBit  = 1;
  localparam int unsigned ApIdleBit  = 2;

  // Values written by the init sequence
  localparam int unsigned GieValue     = 32'h1;
  localparam int unsigned IerValue     = 32'h3;
  localparam int unsigned ApStartValue = 32'h1 << ApStartBit;

  typedef enum logic [1:0] {
    ErrNone    = 2'd0,
    ErrBresp   = 2'd1,
    ErrRresp   = 2'd2,
    ErrTimeout = 2'd3
  } err_code_e;

  typedef enum logic [3:0] {
    StIdle,
    StWrGie,
    StWrIer,
    StWrStart,
    StRdAr,
    StRdR,
    StGap,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/gb_cfg_axil_wr.sv
// gb_cfg_axil_wr: single AXI4-Lite write engine.
// While i_go is high, one write of i_data to i_addr is performed. AW and W are
// raised together and each drops independently after its own handshake; BREADY
// follows once both are accepted. o_ack pulses on the B handshake, with
// o_resp_err flagging a non-OKAY BRESP. The caller must drop i_go (or move to a
// new address) in the cycle after o_ack.
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_go, i_addr, i_data      write request (held for the whole write)
//   o_ack, o_resp_err         completion pulse and BRESP error flag
//   o_aw*, o_w*, i_b*/o_bready AXI4-Lite write channels
module gb_cfg_axil_wr #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_go,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_W-1:0]     i_data,
  output logic                  o_ack,
  output logic                  o_resp_err,
  output logic                  o_awvalid,
  input  logic                  i_awready,
  output logic [ADDR_W-1:0]     o_awaddr,
  output logic                  o_wvalid,
  input  logic                  i_wready,
  output logic [DATA_W-1:0]     o_wdata,
  output logic [DATA_W/8-1:0]   o_wstrb,
  input  logic                  i_bvalid,
  output logic                  o_bready,
  input  logic [1:0]            i_bresp
);

  logic r_aw_done;
  logic r_w_done;
  logic w_ack;

  assign o_awvalid = i_go & ~r_aw_done;
  assign o_wvalid  = i_go & ~r_w_done;
  assign o_bready  = i_go & r_aw_done & r_w_done;
  assign w_ack     = o_bready & i_bvalid;

  assign o_ack      = w_ack;
  assign o_resp_err = w_ack & (i_bresp != 2'b00);

  // Address/data come straight from the caller's state, so they are stable
  // for as long as the matching VALID is high.
  assign o_awaddr = i_go ? i_addr : '0;
  assign o_wdata  = i_go ? i_data : '0;
  assign o_wstrb  = i_go ? '1 : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (!i_go || w_ack) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (o_awvalid && i_awready) r_aw_done <= 1'b1;
      if (o_wvalid && i_wready)   r_w_done  <= 1'b1;
    end
  end

endmodule

// File: rtl/gb_cfg_axil_master.sv
// gb_cfg_axil_master: AXI4-Lite initiator for the Gaussian-blur s_axi_config
// slave. On cmd_start it optionally programs GIE/IER, writes ap_start, then
// polls AP_CTRL until ap_done (or a response error / poll timeout).
// Ports:
//   ap_clk, ap_rst_n          clock, async active-low reset
//   cmd_start, cmd_irq_en     run request and interrupt-enable option
//   busy, done, error         status (done is a pulse, error is sticky)
//   err_code, poll_count      error cause and AP_CTRL reads in this run
//   m_axi_*                   AXI4-Lite master channels
module gb_cfg_axil_master
  import gb_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned POLL_GAP = 4,
  parameter int unsigned POLL_MAX = 1000
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                cmd_start,
  input  logic                cmd_irq_en,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [1:0]          err_code,
  output logic [15:0]         poll_count,
  output logic                m_axi_AWVALID,
  input  logic                m_axi_AWREADY,
  output logic [ADDR_W-1:0]   m_axi_AWADDR,
  output logic                m_axi_WVALID,
  input  logic                m_axi_WREADY,
  output logic [DATA_W-1:0]   m_axi_WDATA,
  output logic [DATA_W/8-1:0] m_axi_WSTRB,
  input  logic                m_axi_BVALID,
  output logic                m_axi_BREADY,
  input  logic [1:0]          m_axi_BRESP,
  output logic                m_axi_ARVALID,
  input  logic                m_axi_ARREADY,
  output logic [ADDR_W-1:0]   m_axi_ARADDR,
  input  logic                m_axi_RVALID,
  output logic                m_axi_RREADY,
  input  logic [DATA_W-1:0]   m_axi_RDATA,
  input  logic [1:0]          m_axi_RRESP
);

  state_e              r_state;
  state_e              w_state_d;
  state_e              w_wr_next;
  logic [15:0]         r_poll_count;
  logic [15:0]         r_gap_cnt;
  logic                r_error;
  err_code_e           r_err_code;
  err_code_e           w_err_code;
  logic                w_set_err;
  logic                w_start_acc;
  logic                w_wr_go;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [DATA_W-1:0]   w_wr_data;
  logic                w_wr_ack;
  logic                w_wr_resp_err;
  logic                w_ar_hs;
  logic                w_gap_last;
  logic                w_unused_rdata;

  assign w_ar_hs        = m_axi_ARVALID & m_axi_ARREADY;
  assign w_gap_last     = ({16'd0, r_gap_cnt} + 32'd1) >= POLL_GAP;
  assign w_unused_rdata = ^m_axi_RDATA;

  gb_cfg_axil_wr #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr (
    .i_clk      (ap_clk),
    .i_rst_n    (ap_rst_n),
    .i_go       (w_wr_go),
    .i_addr     (w_wr_addr),
    .i_data     (w_wr_data),
    .o_ack      (w_wr_ack),
    .o_resp_err (w_wr_resp_err),
    .o_awvalid  (m_axi_AWVALID),
    .i_awready  (m_axi_AWREADY),
    .o_awaddr   (m_axi_AWADDR),
    .o_wvalid   (m_axi_WVALID),
    .i_wready   (m_axi_WREADY),
    .o_wdata    (m_axi_WDATA),
    .o_wstrb    (m_axi_WSTRB),
    .i_bvalid   (m_axi_BVALID),
    .o_bready   (m_axi_BREADY),
    .i_bresp    (m_axi_BRESP)
  );

  always_comb begin
    w_state_d   = r_state;
    w_wr_next   = StIdle;
    w_wr_go     = 1'b0;
    w_wr_addr   = '0;
    w_wr_data   = '0;
    w_set_err   = 1'b0;
    w_err_code  = ErrNone;
    w_start_acc = 1'b0;

    unique case (r_state)
      // DONE/ERR last one cycle and are not busy, so a start is accepted there too.
      StIdle, StDone, StErr: begin
        w_state_d = StIdle;
        if (cmd_start) begin
          w_start_acc = 1'b1;
          w_state_d   = cmd_irq_en ? StWrGie : StWrStart;
        end
      end
      StWrGie: begin
        w_wr_go   = 1'b1;
        w_wr_addr = ADDR_W'(AddrGie);
        w_wr_data = DATA_W'(GieValue);
        w_wr_next = StWrIer;
      end
      StWrIer: begin
        w_wr_go   = 1'b1;
        w_wr_addr = ADDR_W'(AddrIer);
        w_wr_data = DATA_W'(IerValue);
        w_wr_next = StWrStart;
      end
      StWrStart: begin
        w_wr_go   = 1'b1;
        w_wr_addr = ADDR_W'(AddrApCtrl);
        w_wr_data = DATA_W'(ApStartValue);
        w_wr_next = StRdAr;
      end
      StRdAr: begin
        if (m_axi_ARREADY) w_state_d = StRdR;
      end
      StRdR: begin
        if (m_axi_RVALID) begin
          if (m_axi_RRESP != 2'b00) begin
            w_state_d  = StErr;
            w_set_err  = 1'b1;
            w_err_code = ErrRresp;
          end else if (m_axi_RDATA[ApDoneBit]) begin
            w_state_d = StDone;
          end else if ({16'd0, r_poll_count} >= POLL_MAX) begin
            w_state_d  = StErr;
            w_set_err  = 1'b1;
            w_err_code = ErrTimeout;
          end else if (POLL_GAP == 0) begin
            w_state_d = StRdAr;
          end else begin
            w_state_d = StGap;
          end
        end
      end
      StGap: begin
        if (w_gap_last) w_state_d = StRdAr;
      end
      default: w_state_d = StIdle;
    endcase

    // A failed write stops the sequence; nothing further is written.
    if (w_wr_go && w_wr_ack) begin
      if (w_wr_resp_err) begin
        w_state_d  = StErr;
        w_set_err  = 1'b1;
        w_err_code = ErrBresp;
      end else begin
        w_state_d = w_wr_next;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_poll_count <= '0;
      r_gap_cnt    <= '0;
      r_error      <= 1'b0;
      r_err_code   <= ErrNone;
    end else begin
      if (w_start_acc) begin
        r_poll_count <= '0;
      end else if (w_ar_hs && (r_poll_count != 16'hFFFF)) begin
        r_poll_count <= r_poll_count + 16'd1;
      end

      if (r_state == StGap) begin
        r_gap_cnt <= r_gap_cnt + 16'd1;
      end else begin
        r_gap_cnt <= '0;
      end

      if (w_start_acc) begin
        r_error    <= 1'b0;
        r_err_code <= ErrNone;
      end else if (w_set_err) begin
        r_error    <= 1'b1;
        r_err_code <= w_err_code;
      end
    end
  end

  assign m_axi_ARVALID = (r_state == StRdAr);
  assign m_axi_ARADDR  = ADDR_W'(AddrApCtrl);
  assign m_axi_RREADY  = (r_state == StRdR);

  assign busy       = !(r_state inside {StIdle, StDone, StErr});
  assign done       = (r_state == StDone);
  assign error      = r_error;
  assign err_code   = r_err_code;
  assign poll_count = r_poll_count;

endmodule

// File: tb/tb_gb_cfg_axil_master.sv
// Self-checking bench for gb_cfg_axil_master: a behavioural AXI4-Lite slave with
// configurable/random READY and response delays, plus a run-level model of the
// expected write sequence, read count and final status.
module tb_gb_cfg_axil_master;

  localparam int unsigned AddrW   = 5;
  localparam int unsigned DataW   = 32;
  localparam int unsigned PollGap = 2;
  localparam int unsigned PollMax = 5;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  logic cmd_start = 1'b0;
  logic cmd_irq_en = 1'b0;
  logic busy, done, error;
  logic [1:0] err_code;
  logic [15:0] poll_count;
  logic m_axi_AWVALID, m_axi_AWREADY;
  logic [AddrW-1:0] m_axi_AWADDR;
  logic m_axi_WVALID, m_axi_WREADY;
  logic [DataW-1:0] m_axi_WDATA;
  logic [DataW/8-1:0] m_axi_WSTRB;
  logic m_axi_BVALID, m_axi_BREADY;
  logic [1:0] m_axi_BRESP;
  logic m_axi_ARVALID, m_axi_ARREADY;
  logic [AddrW-1:0] m_axi_ARADDR;
  logic m_axi_RVALID, m_axi_RREADY;
  logic [DataW-1:0] m_axi_RDATA;
  logic [1:0] m_axi_RRESP;

  always #5 ap_clk = ~ap_clk;

  gb_cfg_axil_master #(
    .ADDR_W   (AddrW),
    .DATA_W   (DataW),
    .POLL_GAP (PollGap),
    .POLL_MAX (PollMax)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .cmd_start     (cmd_start),
    .cmd_irq_en    (cmd_irq_en),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_code      (err_code),
    .poll_count    (poll_count),
    .m_axi_AWVALID (m_axi_AWVALID),
    .m_axi_AWREADY (m_axi_AWREADY),
    .m_axi_AWADDR  (m_axi_AWADDR),
    .m_axi_WVALID  (m_axi_WVALID),
    .m_axi_WREADY  (m_axi_WREADY),
    .m_axi_WDATA   (m_axi_WDATA),
    .m_axi_WSTRB   (m_axi_WSTRB),
    .m_axi_BVALID  (m_axi_BVALID),
    .m_axi_BREADY  (m_axi_BREADY),
    .m_axi_BRESP   (m_axi_BRESP),
    .m_axi_ARVALID (m_axi_ARVALID),
    .m_axi_ARREADY (m_axi_ARREADY),
    .m_axi_ARADDR  (m_axi_ARADDR),
    .m_axi_RVALID  (m_axi_RVALID),
    .m_axi_RREADY  (m_axi_RREADY),
    .m_axi_RDATA   (m_axi_RDATA),
    .m_axi_RRESP   (m_axi_RRESP)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave state
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  int aw_wait, w_wait, b_wait, ar_wait, r_wait;
  bit rand_dly;
  bit got_aw, got_w, r_pend, r_shown;
  logic [AddrW-1:0] cur_addr;
  logic [DataW-1:0] cur_data;
  logic [DataW-1:0] r_data_hold;
  logic [AddrW-1:0] wr_addr_log[$];
  logic [DataW-1:0] wr_data_log[$];
  int wr_idx, read_count, done_at, bad_wr, bad_rd, done_pulses;
  // Expectations for the cycle after a B or R handshake
  bit prev_aw_hs, prev_w_hs, prev_b_hs, prev_r_hs;
  bit nx_done, nx_err;
  logic [1:0] nx_code;

  task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  task automatic roll_delays();
    if (rand_dly) begin
      set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  task automatic reset_slave();
    m_axi_AWREADY = 1'b0; m_axi_WREADY = 1'b0; m_axi_BVALID = 1'b0; m_axi_BRESP = 2'b00;
    m_axi_ARREADY = 1'b0; m_axi_RVALID = 1'b0; m_axi_RDATA = '0; m_axi_RRESP = 2'b00;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    got_aw = 0; got_w = 0; r_pend = 0; r_shown = 0;
    prev_aw_hs = 0; prev_w_hs = 0; prev_b_hs = 0; prev_r_hs = 0;
  endtask

  // One clock: check last cycle's handshake consequences, then drive the slave.
  task automatic tick();
    @(posedge ap_clk);
    #1;
    if (done) done_pulses++;
    if (prev_aw_hs) check_eq("awvalid_drop", m_axi_AWVALID, 1'b0);
    if (prev_w_hs) check_eq("wvalid_drop", m_axi_WVALID, 1'b0);
    if (prev_b_hs || prev_r_hs) begin
      check_eq("resp_done", done, nx_done);
      check_eq("resp_error", error, nx_err);
      check_eq("resp_busy", busy, !(nx_done || nx_err));
      if (nx_err) check_eq("resp_code", err_code, nx_code);
    end
    prev_aw_hs = 0; prev_w_hs = 0; prev_b_hs = 0; prev_r_hs = 0;

    m_axi_AWREADY = 1'b0;
    if (m_axi_AWVALID && !got_aw) begin
      m_axi_AWREADY = (aw_wait >= aw_dly);
      aw_wait++;
      if (m_axi_AWREADY) begin
        got_aw = 1; cur_addr = m_axi_AWADDR; prev_aw_hs = 1;
      end
    end

    m_axi_WREADY = 1'b0;
    if (m_axi_WVALID && !got_w) begin
      m_axi_WREADY = (w_wait >= w_dly);
      w_wait++;
      if (m_axi_WREADY) begin
        got_w = 1; cur_data = m_axi_WDATA; prev_w_hs = 1;
        check_eq("wstrb", m_axi_WSTRB, 4'hF);
      end
    end

    m_axi_BVALID = 1'b0;
    m_axi_BRESP  = 2'b00;
    if (got_aw && got_w && !prev_aw_hs && !prev_w_hs) begin
      if (b_wait >= b_dly) begin
        m_axi_BVALID = 1'b1;
        m_axi_BRESP  = (wr_idx == bad_wr) ? 2'b10 : 2'b00;
        if (m_axi_BREADY) begin
          wr_addr_log.push_back(cur_addr);
          wr_data_log.push_back(cur_data);
          prev_b_hs = 1; nx_done = 0; nx_err = (wr_idx == bad_wr); nx_code = 2'd1;
          wr_idx++;
          got_aw = 0; got_w = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
          roll_delays();
        end
      end else begin
        b_wait++;
      end
    end

    m_axi_RVALID = 1'b0;
    m_axi_RDATA  = '0;
    m_axi_RRESP  = 2'b00;
    if (r_pend) begin
      if (r_wait >= r_dly) begin
        if (!r_shown) begin
          r_shown = 1;
          r_data_hold = ($urandom() & ~32'h2) | ((read_count == done_at) ? 32'h2 : 32'h0);
        end
        m_axi_RVALID = 1'b1;
        m_axi_RDATA  = r_data_hold;
        m_axi_RRESP  = (read_count == bad_rd) ? 2'b10 : 2'b00;
        if (m_axi_RREADY) begin
          prev_r_hs = 1; r_pend = 0; r_shown = 0; r_wait = 0;
          nx_done = 0; nx_err = 0; nx_code = 2'd0;
          if (read_count == bad_rd) begin
            nx_err = 1; nx_code = 2'd2;
          end else if (r_data_hold[1]) begin
            nx_done = 1;
          end else if (read_count >= PollMax) begin
            nx_err = 1; nx_code = 2'd3;
          end
          roll_delays();
        end
      end else begin
        r_wait++;
      end
    end

    m_axi_ARREADY = 1'b0;
    if (m_axi_ARVALID && !r_pend) begin
      m_axi_ARREADY = (ar_wait >= ar_dly);
      ar_wait++;
      if (m_axi_ARREADY) begin
        check_eq("araddr", m_axi_ARADDR, 0);
        check_eq("ar_during_write", {got_aw, got_w, m_axi_AWVALID, m_axi_WVALID}, 4'b0);
        read_count++; r_pend = 1; ar_wait = 0;
      end
    end
  endtask

  task automatic run_cmd(input string name, input bit irq, input int d_at, input int b_wr,
                         input int b_rd);
    logic [AddrW-1:0] exp_addr[$];
    logic [DataW-1:0] exp_data[$];
    int exp_reads;
    logic [1:0] exp_code;
    int k;
    if (irq) begin
      exp_addr.push_back(5'h04); exp_data.push_back(32'h1);
      exp_addr.push_back(5'h08); exp_data.push_back(32'h3);
    end
    exp_addr.push_back(5'h00); exp_data.push_back(32'h1);
    if (b_wr >= 0 && b_wr < exp_addr.size()) begin
      while (exp_addr.size() > b_wr + 1) begin
        void'(exp_addr.pop_back()); void'(exp_data.pop_back());
      end
      exp_reads = 0; exp_code = 2'd1;
    end else begin
      exp_reads = PollMax; exp_code = 2'd3;
      if (d_at >= 1 && d_at <= exp_reads) begin exp_reads = d_at; exp_code = 2'd0; end
      if (b_rd >= 1 && b_rd <= exp_reads) begin exp_reads = b_rd; exp_code = 2'd2; end
    end

    wr_addr_log.delete(); wr_data_log.delete();
    wr_idx = 0; read_count = 0; done_pulses = 0;
    done_at = d_at; bad_wr = b_wr; bad_rd = b_rd;
    roll_delays();

    cmd_irq_en = irq;
    cmd_start  = 1'b1;
    tick();
    cmd_start  = 1'b0;
    cmd_irq_en = 1'($urandom_range(0, 1));
    check_eq({name, "_lat_awvalid"}, m_axi_AWVALID, 1'b1);
    check_eq({name, "_lat_busy"}, busy, 1'b1);
    check_eq({name, "_lat_err_clr"}, error, 1'b0);

    k = 0;
    while (!(done || error) && k < 400) begin
      cmd_start = (k == 4) && busy;  // must be ignored
      tick();
      cmd_start = 1'b0;
      k++;
    end
    check_eq({name, "_finished"}, k < 400, 1'b1);
    repeat (3) tick();

    check_eq({name, "_n_writes"}, wr_addr_log.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < wr_addr_log.size(); i++) begin
      check_eq($sformatf("%s_waddr%0d", name, i), wr_addr_log[i], exp_addr[i]);
      check_eq($sformatf("%s_wdata%0d", name, i), wr_data_log[i], exp_data[i]);
    end
    check_eq({name, "_n_reads"}, read_count, exp_reads);
    check_eq({name, "_poll_count"}, poll_count, exp_reads);
    check_eq({name, "_error"}, error, exp_code != 2'd0);
    check_eq({name, "_err_code"}, err_code, exp_code);
    check_eq({name, "_done_pulses"}, done_pulses, exp_code == 2'd0);
    check_eq({name, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    int k;
    rand_dly = 0;
    bad_wr = -1; bad_rd = 0; done_at = 0; wr_idx = 0; read_count = 0; done_pulses = 0;
    reset_slave();
    set_dly(0, 0, 0, 0, 0);
    #3;
    check_eq("reset_outputs", {m_axi_AWVALID, m_axi_WVALID, m_axi_BREADY, m_axi_ARVALID,
                               m_axi_RREADY, busy, done, error, err_code}, 0);
    check_eq("reset_poll_count", poll_count, 0);
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    tick();

    run_cmd("zero_wait", 0, 3, -1, 0);
    run_cmd("irq_en", 1, 2, -1, 0);
    set_dly(2, 0, 0, 0, 0);
    run_cmd("w_first", 1, 1, -1, 0);
    set_dly(0, 2, 1, 0, 0);
    run_cmd("aw_first", 1, 1, -1, 0);
    set_dly(0, 0, 0, 0, 0);
    run_cmd("bresp_err", 0, 1, 0, 0);
    run_cmd("bresp_err_ier", 1, 1, 1, 0);
    run_cmd("timeout", 0, 0, -1, 0);
    run_cmd("rresp_err", 0, 4, -1, 2);

    // Reset while ARVALID is held high by a slow slave
    bad_wr = -1; bad_rd = 0; done_at = 2; read_count = 0; wr_idx = 0;
    set_dly(0, 0, 0, 40, 0);
    cmd_irq_en = 1'b0;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    k = 0;
    while (!m_axi_ARVALID && k < 30) begin
      tick();
      k++;
    end
    check_eq("rst_reached_ar", m_axi_ARVALID, 1'b1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check_eq("rst_async_outputs", {m_axi_AWVALID, m_axi_WVALID, m_axi_BREADY, m_axi_ARVALID,
                                   m_axi_RREADY, busy, done, error, err_code}, 0);
    check_eq("rst_async_poll", poll_count, 0);
    reset_slave();
    set_dly(0, 0, 0, 0, 0);
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    tick();
    run_cmd("post_rst", 0, 2, -1, 0);

    rand_dly = 1;
    for (int i = 0; i < 16; i++) begin
      bit irq;
      int d_at, b_wr, b_rd;
      irq  = 1'($urandom_range(0, 1));
      d_at = $urandom_range(1, PollMax + 1);
      b_wr = ($urandom_range(0, 5) == 0) ? $urandom_range(0, irq ? 2 : 0) : -1;
      b_rd = ($urandom_range(0, 5) == 0) ? $urandom_range(1, PollMax) : 0;
      run_cmd($sformatf("rand%0d", i), irq, d_at, b_wr, b_rd);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/gb_cfg_axil_master.md
Name: gb_cfg_axil_master

Overview:
- AXI4-Lite initiator that drives the Gaussian-blur accelerator's s_axi_config slave: programs interrupt enables, pulses ap_start, then polls AP_CTRL until ap_done.
- Sits between the testbench/host sequencer and hls_target.
- Lets the equivalence and system benches run the HLS core without hand-written AXI-Lite stimulus.

Parameters:
- ADDR_W, 5, AXI-Lite address width (matches C_S_AXI_CONFIG_ADDR_WIDTH)
- DATA_W, 32, AXI-Lite data width; WSTRB width is DATA_W/8
- POLL_GAP, 4, idle cycles between consecutive AP_CTRL reads (0 allowed)
- POLL_MAX, 1000, maximum AP_CTRL reads before timeout error

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- cmd_start  in  1  one-cycle request to run one accelerator invocation; ignored while busy
- cmd_irq_en  in  1  sampled with cmd_start; 1 = program GIE and IER before starting
- busy  out  1  high from the cycle after an accepted cmd_start until done/error
- done  out  1  one-cycle pulse when ap_done is observed
- error  out  1  sticky until the next accepted cmd_start
- err_code  out  2  0 none, 1 BRESP!=0, 2 RRESP!=0, 3 timeout
- poll_count  out  16  number of AP_CTRL reads issued in the current run; saturates at 16'hFFFF
- m_axi_AWVALID/AWREADY/AWADDR  out/in/out  1/1/ADDR_W  write address channel
- m_axi_WVALID/WREADY/WDATA/WSTRB  out/in/out/out  1/1/DATA_W/DATA_W/8  write data channel
- m_axi_BVALID/BREADY/BRESP  in/out/in  1/1/2  write response channel
- m_axi_ARVALID/ARREADY/ARADDR  out/in/out  1/1/ADDR_W  read address channel
- m_axi_RVALID/RREADY/RDATA/RRESP  in/out/in/in  1/1/DATA_W/2  read data channel

Behaviour:
- Register map (constants): AP_CTRL 0x00 (bit0 ap_start, bit1 ap_done, bit2 ap_idle); GIE 0x04; IER 0x08.
- Reset: all outputs 0, FSM in IDLE, counters cleared. Reset mid-transaction aborts immediately; no completion of the outstanding beat.
- Top FSM: IDLE -> (cmd_irq_en ? WR_GIE -> WR_IER : -) -> WR_START -> RD_AR -> RD_R -> GAP -> RD_AR ... -> DONE -> IDLE. Any error -> ERR -> IDLE.
  - WR_GIE writes 1 to GIE; WR_IER writes 3 to IER; WR_START writes 1 to AP_CTRL. WSTRB is always 4'hF.
- Write transaction:
  - AWVALID and WVALID rise together on state entry.
  - Each drops the cycle after its own READY is sampled high; either order or the same cycle is legal.
  - BREADY goes high once both are accepted and stays high until BVALID.
  - AWADDR/WDATA are stable while the corresponding VALID is high.
- Read transaction:
  - ARVALID is held with a stable ARADDR=0 until ARREADY.
  - RREADY is high in RD_R; data is captured on RVALID&RREADY.
  - poll_count increments when AR is accepted.
- Poll decision on the captured beat:
  - RRESP!=0 -> ERR, code 2.
  - RDATA[1]=1 -> DONE.
  - Else if poll_count==POLL_MAX -> ERR, code 3.
  - Else GAP for POLL_GAP cycles, then RD_AR.
- Write response: BRESP!=0 -> ERR, code 1, and no further writes are issued.
- Latency:
  - cmd_start(cycle 0) -> AWVALID at cycle 1.
  - With zero-wait slaves: a write takes 3 cycles (AW/W, B, next state).
  - done pulses the cycle after the captured RDATA with bit1 set; busy falls in the same cycle.
- Ordering: never more than one outstanding transaction; AR is never issued while a write is in flight.
- cmd_start while busy: ignored, no effect on error or poll_count.

Decomposition:
- Package gb_cfg_pkg holds:
  - the register address constants and AP_CTRL bit positions;
  - the err_code enum values;
  - the top-state encoding typedef.
- One sub-module, gb_cfg_axil_wr: the single-write engine.
  - Inputs: go, addr, data.
  - Outputs: ack, resp_err.
  - Drives the AW/W/B channels; instantiated once and sequenced by the top FSM.

Test Plan:
- Zero-wait slave, cmd_irq_en=0, ap_done on 3rd read -> exactly one write (0x00<-1), poll_count=3, done pulse, error=0.
- cmd_irq_en=1 -> writes in order 0x04<-1, 0x08<-3, 0x00<-1, then polling; check all three addr/data pairs.
- Slave asserts WREADY 2 cycles before AWREADY (and a case with the reverse order) -> each VALID drops independently; a single B handshake is accepted.
- BRESP=2'b10 on the start write -> error=1, err_code=1, no AR issued, busy low next cycle.
- POLL_MAX=5, ap_done never set -> exactly 5 reads, err_code=3, poll_count=5.
- ap_rst_n low while ARVALID is high -> all outputs 0 asynchronously; a new cmd_start after release runs cleanly from poll_count=0.
